baccarat_ctrl: RTL
==================

# baccarat_ctrl

Sequencing controller for the baccarat datapath: a Moore state machine on `slow_clock` that issues the six card-load strobes in dealing order and applies the natural, player-third-card and banker-third-card tableau rules. It uses the player score, dealer score and player third card returned by the datapath. It drives the win lights when the hand ends. One instance sits beside the datapath in the top level; it holds no card values itself.

## Interface
- No parameters; all widths are fixed by the card encoding (4-bit rank, 1=A … 13=K, 0=no card).
- `slow_clock`  in  1  sole clock; all state changes on the rising edge
- `resetb`  in  1  asynchronous, active-high reset (asserted = 1); forces IDLE immediately
- `pscore`  in  4  player hand score 0..9 from datapath (combinational from loaded cards)
- `dscore`  in  4  dealer hand score 0..9 from datapath
- `pcard3`  in  4  player third-card rank, 0 if not dealt
- `load_pcard1`, `load_pcard2`, `load_pcard3`  out  1 each  player card load strobes
- `load_dcard1`, `load_dcard2`, `load_dcard3`  out  1 each  dealer card load strobes
- `hand_done`  out  1  high while in DONE
- `player_win_light`  out  1  player won or tie
- `dealer_win_light`  out  1  dealer won or tie

## Operation
- States: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK, DEAL_P3, BANKER_CHECK, DEAL_D3, DONE.
- All outputs are Moore outputs; all are 0 in reset and in IDLE.
- Exactly one load strobe is high in each DEAL_xx state: DEAL_P1→`load_pcard1`, DEAL_D1→`load_dcard1`, and so on. No strobe is high in any other state.
- Fixed path: IDLE → DEAL_P1 → DEAL_D1 → DEAL_P2 → DEAL_D2 → CHECK, one cycle each.
- Transitions out of CHECK, first match wins:
  - `pscore`≥8 or `dscore`≥8 (natural) → DONE.
  - `pscore`≤5 → DEAL_P3.
  - Otherwise (player stands on 6/7): `dscore`≤5 → DEAL_D3, else → DONE.
- DEAL_P3 → BANKER_CHECK.
- Banker rule in BANKER_CHECK uses v = value(`pcard3`), where rank ≥10 gives 0, else the rank itself. Banker draws (→ DEAL_D3, otherwise → DONE) when:
  - `dscore` 0–2: always.
  - `dscore` 3: v≠8.
  - `dscore` 4: v in 2..7.
  - `dscore` 5: v in 4..7.
  - `dscore` 6: v in 6..7.
  - `dscore` 7: never.
- DEAL_D3 → DONE.
- DONE is terminal until `resetb`.
- In DONE:
  - `hand_done`=1.
  - `player_win_light`=(`pscore`≥`dscore`).
  - `dealer_win_light`=(`dscore`≥`pscore`).
  - A tie lights both.
- Score inputs are treated as unsigned 4-bit. Values >9 are out of contract and need not be handled specially.

## Timing
- Each state lasts exactly one `slow_clock` cycle, except DONE.
- A load strobe high in a state is captured by the datapath on the edge that leaves that state.
- Scores sampled in CHECK reflect four cards. `pcard3` sampled in BANKER_CHECK reflects the new player card.
- Shortest hand is 6 edges from reset release to DONE: IDLE, P1, D1, P2, D2, CHECK.
- Longest hand is 9 edges to DONE.
- Reset asserted mid-hand, including during a strobe, drops all outputs to 0 asynchronously. The datapath's own reset clears its cards; the FSM restarts from IDLE on the first edge after release.
- Exactly one or zero strobes are ever high simultaneously; no glitches, since outputs decode registered state only.

## Structure
- Shared package `baccarat_pkg` holds:
  - `state_t` enum.
  - Rank constants (`RANK_NONE`=0, `RANK_TEN`=10).
  - Function `card_value(rank)` returning 0..9.
- Sub-module `banker_draw`: combinational, inputs `dscore` and `pcard3`, output `draw`. It implements the BANKER_CHECK table only and is unit-testable in isolation.
- Controller holds the state register (always_ff with async reset), next-state logic and output decode.

## Test plan
- Reset, then deal; after release, bench scores stay 0/0:
  - Strobes appear in order P1, D1, P2, D2 on consecutive cycles.
  - Player draws (P3), BANKER_CHECK with `dscore`=0 → D3 → DONE.
  - Both lights 1 (tie 0–0).
- Natural: in CHECK `pscore`=9, `dscore`=3 → DONE next cycle, no third strobes; `player_win_light`=1, `dealer_win_light`=0.
- Player stands: CHECK `pscore`=7, `dscore`=5 → DEAL_D3 → DONE; `load_pcard3` never asserted.
- Player stands: CHECK `pscore`=6, `dscore`=6 → DONE; no third cards.
- Banker table sweep: `dscore` 0..7 × `pcard3` 0..13 in BANKER_CHECK. Draw matches the rule; e.g. (3, rank 8) → DONE, (6, rank 7) → DEAL_D3, (4, rank 12) → DONE.
- Async reset asserted during DEAL_P2: all outputs 0 before the next edge; after release, the sequence restarts at IDLE → DEAL_P1.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat sequencing controller.
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        CHECK,
        DEAL_P3,
        BANKER_CHECK,
        DEAL_D3,
        DONE
    } state_t;

    localparam logic [3:0] RANK_NONE = 4'd0;
    localparam logic [3:0] RANK_TEN  = 4'd10;

    // Tens and face cards count as zero; every other rank scores its face value.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= RANK_TEN) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/banker_draw.sv
// Banker third-card decision, given the banker score and the player's third card.
module banker_draw
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] v;

    // NOTE: every signal driven here gets a value before the case, so no latch is inferred.
    always_comb begin
        v    = card_value(pcard3);
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_ctrl.sv
// Moore sequencer for one baccarat hand: deals four cards, applies the tableau
// rules for third cards, then lights the winner until the next reset.
module baccarat_ctrl
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       hand_done,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    state_t state;
    state_t next_state;
    logic   banker_draws;

    banker_draw u_banker_draw (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draws)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = DEAL_P1;
            DEAL_P1: next_state = DEAL_D1;
            DEAL_D1: next_state = DEAL_P2;
            DEAL_P2: next_state = DEAL_D2;
            DEAL_D2: next_state = CHECK;
            CHECK: begin
                if (pscore >= 4'd8 || dscore >= 4'd8) next_state = DONE;
                else if (pscore <= 4'd5)              next_state = DEAL_P3;
                else if (dscore <= 4'd5)              next_state = DEAL_D3;
                else                                  next_state = DONE;
            end
            DEAL_P3:      next_state = BANKER_CHECK;
            BANKER_CHECK: next_state = banker_draws ? DEAL_D3 : DONE;
            DEAL_D3:      next_state = DONE;
            DONE:         next_state = DONE;
            default:      next_state = IDLE;
        endcase
    end

    // Strobes are registered from next_state so each one is a clean flop output
    // aligned exactly with the state it belongs to.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            state       <= IDLE;
            load_pcard1 <= 1'b0;
            load_pcard2 <= 1'b0;
            load_pcard3 <= 1'b0;
            load_dcard1 <= 1'b0;
            load_dcard2 <= 1'b0;
            load_dcard3 <= 1'b0;
            hand_done   <= 1'b0;
        end else begin
            state       <= next_state;
            load_pcard1 <= (next_state == DEAL_P1);
            load_pcard2 <= (next_state == DEAL_P2);
            load_pcard3 <= (next_state == DEAL_P3);
            load_dcard1 <= (next_state == DEAL_D1);
            load_dcard2 <= (next_state == DEAL_D2);
            load_dcard3 <= (next_state == DEAL_D3);
            hand_done   <= (next_state == DONE);
        end
    end

    // Lights follow the live scores so a third banker card loaded on entry to DONE counts.
    assign player_win_light = hand_done && (pscore >= dscore);
    assign dealer_win_light = hand_done && (dscore >= pscore);

endmodule
